// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and transaction status between a
// requester (master) and the PS/2 host transmitter (slave).
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic [1:0] err_code;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  busy,
      input  done,
      input  ack_ok,
      input  err_code
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output busy,
      output done,
      output ack_ok,
      output err_code
   );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, then shifts out one byte
// (LSB first, odd parity, stop) on device-generated falling clock edges
// and checks the device ACK. Line drivers are pull-low enables.
// Optional feature macro: PS2_TX_RETRY_EN -- one automatic re-run from
// INHIBIT after a NACK or transfer timeout (start timeouts never retry).
module ps2_host_tx #(
   parameter int INHIBIT_CYC       = 10000,
   parameter int START_TIMEOUT_CYC = 1500000,
   parameter int XFER_TIMEOUT_CYC  = 200000
) (
   input  logic         clk,
   input  logic         rst,
   ps2_host_tx_if.slave tx_if,
   input  logic         ps2_clk_i,
   input  logic         ps2_data_i,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);

   // One shared timer serves inhibit, start timeout and transfer timeout.
   localparam int MAX_AB  = (INHIBIT_CYC > START_TIMEOUT_CYC) ? INHIBIT_CYC : START_TIMEOUT_CYC;
   localparam int MAX_CYC = (MAX_AB > XFER_TIMEOUT_CYC) ? MAX_AB : XFER_TIMEOUT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] INH_LAST    = CNT_W'(INHIBIT_CYC - 1);
   // Count value whose successor cycle is the first of the last 16 (start bit).
   localparam logic [CNT_W-1:0] INH_START_M1 = CNT_W'(INHIBIT_CYC - 17);
   localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] XFER_LAST   = CNT_W'(XFER_TIMEOUT_CYC - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_RTS       = 3'd2;
   localparam logic [2:0] ST_SHIFT     = 3'd3;
   localparam logic [2:0] ST_ACK       = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
   localparam logic [2:0] ST_ABORT     = 3'd6;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_START = 2'b01;
   localparam logic [1:0] ERR_XFER  = 2'b10;
   localparam logic [1:0] ERR_NACK  = 2'b11;

   // Odd parity bit: set when the byte holds an even number of ones.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   logic             clk_s1_r, clk_s2_r, clk_s3_r;
   logic             data_s1_r, data_s2_r;
   logic             fall_s;

   logic [2:0]       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [3:0]       bit_cnt_r, bit_cnt_s;
   logic [7:0]       byte_r, byte_s;
   logic             par_r, par_s;
   logic             clk_oe_r, clk_oe_s;
   logic             data_oe_r, data_oe_s;
   logic             busy_r, busy_s;
   logic             ready_r, ready_s;
   logic             done_r, done_s;
   logic             ack_ok_r, ack_ok_s;
   logic [1:0]       err_r, err_s;
   logic             fail_s;
   logic [1:0]       fail_code_s;
`ifdef PS2_TX_RETRY_EN
   logic             retry_r, retry_s;
`endif

   // Two-flop synchronizers on both raw lines plus a delayed clock copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_r  <= 1'b1;
         clk_s2_r  <= 1'b1;
         clk_s3_r  <= 1'b1;
         data_s1_r <= 1'b1;
         data_s2_r <= 1'b1;
      end else begin
         clk_s1_r  <= ps2_clk_i;
         clk_s2_r  <= clk_s1_r;
         clk_s3_r  <= clk_s2_r;
         data_s1_r <= ps2_data_i;
         data_s2_r <= data_s1_r;
      end
   end

   assign fall_s = clk_s3_r & ~clk_s2_r;

   // Next-state and next-output decode for the transmit sequence.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      bit_cnt_s   = bit_cnt_r;
      byte_s      = byte_r;
      par_s       = par_r;
      clk_oe_s    = clk_oe_r;
      data_oe_s   = data_oe_r;
      busy_s      = busy_r;
      ready_s     = ready_r;
      done_s      = 1'b0;
      ack_ok_s    = ack_ok_r;
      err_s       = err_r;
      fail_s      = 1'b0;
      fail_code_s = ERR_OK;
`ifdef PS2_TX_RETRY_EN
      retry_s     = retry_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (tx_if.tx_valid) begin
               byte_s    = tx_if.tx_data;
               par_s     = odd_parity(tx_if.tx_data);
               state_s   = ST_INHIBIT;
               cnt_s     = '0;
               bit_cnt_s = 4'd0;
               clk_oe_s  = 1'b1;
               data_oe_s = 1'b0;
               busy_s    = 1'b1;
               ready_s   = 1'b0;
`ifdef PS2_TX_RETRY_EN
               retry_s   = 1'b0;
`endif
            end else begin
               clk_oe_s  = 1'b0;
               data_oe_s = 1'b0;
            end
         end
         ST_INHIBIT: begin
            if (cnt_r == INH_LAST) begin
               state_s   = ST_RTS;
               cnt_s     = '0;
               clk_oe_s  = 1'b0;
               data_oe_s = 1'b1;
            end else begin
               cnt_s     = cnt_r + CNT_W'(1);
               clk_oe_s  = 1'b1;
               data_oe_s = (cnt_r >= INH_START_M1);
            end
         end
         ST_RTS: begin
            if (fall_s) begin
               state_s   = ST_SHIFT;
               cnt_s     = '0;
               bit_cnt_s = 4'd1;
               data_oe_s = ~byte_r[0];
            end else if (cnt_r == START_LAST) begin
               state_s   = ST_ABORT;
               clk_oe_s  = 1'b0;
               data_oe_s = 1'b0;
               done_s    = 1'b1;
               ack_ok_s  = 1'b0;
               err_s     = ERR_START;
            end else begin
               cnt_s     = cnt_r + CNT_W'(1);
            end
         end
         ST_SHIFT: begin
            if (cnt_r == XFER_LAST) begin
               fail_s      = 1'b1;
               fail_code_s = ERR_XFER;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
               if (fall_s) begin
                  if (bit_cnt_r < 4'd8) begin
                     data_oe_s = ~byte_r[bit_cnt_r[2:0]];
                     bit_cnt_s = bit_cnt_r + 4'd1;
                  end else if (bit_cnt_r == 4'd8) begin
                     data_oe_s = ~par_r;
                     bit_cnt_s = 4'd9;
                  end else begin
                     data_oe_s = 1'b0;
                     bit_cnt_s = 4'd10;
                     state_s   = ST_ACK;
                  end
               end else begin
                  bit_cnt_s = bit_cnt_r;
               end
            end
         end
         ST_ACK: begin
            if (cnt_r == XFER_LAST) begin
               fail_s      = 1'b1;
               fail_code_s = ERR_XFER;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
               if (fall_s) begin
                  if (!data_s2_r) begin
                     state_s = ST_WAIT_IDLE;
                  end else begin
                     fail_s      = 1'b1;
                     fail_code_s = ERR_NACK;
                  end
               end else begin
                  state_s = ST_ACK;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (done_r) begin
               state_s = ST_IDLE;
               busy_s  = 1'b0;
               ready_s = 1'b1;
            end else if (clk_s2_r && data_s2_r) begin
               done_s   = 1'b1;
               ack_ok_s = 1'b1;
               err_s    = ERR_OK;
            end else begin
               state_s = ST_WAIT_IDLE;
            end
         end
         ST_ABORT: begin
            state_s   = ST_IDLE;
            clk_oe_s  = 1'b0;
            data_oe_s = 1'b0;
            busy_s    = 1'b0;
            ready_s   = 1'b1;
         end
         default: begin
            state_s   = ST_IDLE;
            clk_oe_s  = 1'b0;
            data_oe_s = 1'b0;
            busy_s    = 1'b0;
            ready_s   = 1'b1;
         end
      endcase

      // Retryable failures (NACK, transfer timeout) either re-run or abort.
      if (fail_s) begin
`ifdef PS2_TX_RETRY_EN
         if (!retry_r) begin
            state_s   = ST_INHIBIT;
            cnt_s     = '0;
            bit_cnt_s = 4'd0;
            clk_oe_s  = 1'b1;
            data_oe_s = 1'b0;
            retry_s   = 1'b1;
         end else begin
            state_s   = ST_ABORT;
            clk_oe_s  = 1'b0;
            data_oe_s = 1'b0;
            done_s    = 1'b1;
            ack_ok_s  = 1'b0;
            err_s     = fail_code_s;
         end
`else
         state_s   = ST_ABORT;
         clk_oe_s  = 1'b0;
         data_oe_s = 1'b0;
         done_s    = 1'b1;
         ack_ok_s  = 1'b0;
         err_s     = fail_code_s;
`endif
      end else begin
         state_s = state_s;
      end
   end

   // State, timer, latched byte and registered outputs; reset releases both lines at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         bit_cnt_r <= 4'd0;
         byte_r    <= 8'h00;
         par_r     <= 1'b0;
         clk_oe_r  <= 1'b0;
         data_oe_r <= 1'b0;
         busy_r    <= 1'b0;
         ready_r   <= 1'b1;
         done_r    <= 1'b0;
         ack_ok_r  <= 1'b0;
         err_r     <= 2'b00;
`ifdef PS2_TX_RETRY_EN
         retry_r   <= 1'b0;
`endif
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_cnt_r <= bit_cnt_s;
         byte_r    <= byte_s;
         par_r     <= par_s;
         clk_oe_r  <= clk_oe_s;
         data_oe_r <= data_oe_s;
         busy_r    <= busy_s;
         ready_r   <= ready_s;
         done_r    <= done_s;
         ack_ok_r  <= ack_ok_s;
         err_r     <= err_s;
`ifdef PS2_TX_RETRY_EN
         retry_r   <= retry_s;
`endif
      end
   end

   assign ps2_clk_oe     = clk_oe_r;
   assign ps2_data_oe    = data_oe_r;
   assign tx_if.tx_ready = ready_r;
   assign tx_if.busy     = busy_r;
   assign tx_if.done     = done_r;
   assign tx_if.ack_ok   = ack_ok_r;
   assign tx_if.err_code = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a PS/2 device
// model on open-collector lines, a directed vector table and random
// transactions checked against a frame/outcome reference model.
module tb_ps2_host_tx;
   localparam int INH     = 40;
   localparam int START_T = 2000;
   localparam int XFER_T  = 1000;
   localparam int HALF    = 25;
   localparam int TMO     = 6000;
`ifdef PS2_TX_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   // Device behaviour per attempt: 0 ACK, 1 NACK, 2 stall after s edges, 3 never clocks.
   typedef struct {
      string      name;
      logic [7:0] data;
      int         k1;
      int         s1;
      int         k2;
      int         s2;
      logic [1:0] err;
      logic       ack;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int rel_cnt = 0;
   int done_cyc = 0;
   int rel_cyc = 0;
   int fall_cyc = 0;
   logic [1:0] done_err = 2'b00;
   logic done_ack = 1'b0;
   logic prev_oe = 1'b0;
   logic done_prev = 1'b0;
   logic ready_after = 1'b0;

   ps2_host_tx_if tx_if ();

   ps2_host_tx #(
      .INHIBIT_CYC(INH),
      .START_TIMEOUT_CYC(START_T),
      .XFER_TIMEOUT_CYC(XFER_T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tx_if(tx_if),
      .ps2_clk_i(ps2_clk_i),
      .ps2_data_i(ps2_data_i),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_i = dev_data & ~ps2_data_oe;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: done pulses, result capture, clock-release events.
   always @(negedge clk) begin
      if (tx_if.done) begin
         done_cnt <= done_cnt + 1;
         done_err <= tx_if.err_code;
         done_ack <= tx_if.ack_ok;
         done_cyc <= cyc;
      end
      if (done_prev) ready_after <= tx_if.tx_ready;
      done_prev <= tx_if.done;
      if (prev_oe && !ps2_clk_oe) begin
         rel_cnt <= rel_cnt + 1;
         rel_cyc <= cyc;
      end
      prev_oe <= ps2_clk_oe;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected 10 line bits after the start bit: data LSB first, odd parity, stop.
   function automatic logic [9:0] frame_of(input logic [7:0] b);
      logic [9:0] f;
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         f[i] = b[i];
         if (b[i]) ones++;
      end
      f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
      f[9] = 1'b1;
      return f;
   endfunction

   // Outcome {ack_ok, err_code} of a transaction from the device behaviour.
   function automatic logic [2:0] model_outcome(input int k1, input int k2);
      int k;
      k = k1;
      if (RETRY && (k1 == 1 || k1 == 2)) k = k2;
      case (k)
         0:       return 3'b100;
         1:       return 3'b011;
         2:       return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   task automatic dev_attempt(input int kind, input int stall_k, input int want_rel, input logic [7:0] b);
      int t;
      int n_edges;
      logic [9:0] got;
      logic [9:0] mask;
      t = 0;
      while (rel_cnt < want_rel && t < TMO) begin
         @(negedge clk);
         t++;
      end
      chk("release_seen", 32'(t < TMO), 32'd1);
      if (t >= TMO) return;
      chk("start_bit_drive", 32'(ps2_data_oe), 32'd1);
      tx_if.tx_data  = ~b;
      tx_if.tx_valid = 1'b1;
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
      if (kind == 3) return;
      n_edges = (kind == 2) ? stall_k : 10;
      repeat (10) @(negedge clk);
      got = '0;
      for (int e = 0; e < n_edges; e++) begin
         dev_clk = 1'b0;
         if (e == 0) fall_cyc = cyc;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         got[e] = ps2_data_i;
         repeat (HALF) @(negedge clk);
      end
      mask = 10'((11'd1 << n_edges) - 11'd1);
      chk("frame_bits", 32'(got & mask), 32'(frame_of(b) & mask));
      if (kind == 0 || kind == 1) begin
         if (kind == 0) dev_data = 1'b0;
         repeat (HALF / 2) @(negedge clk);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         repeat (HALF / 2) @(negedge clk);
         dev_data = 1'b1;
      end
   endtask

   task automatic do_txn(input string nm, input logic [7:0] b, input int k1, input int s1,
                         input int k2, input int s2, input logic [1:0] exp_err, input logic exp_ack);
      int base_done, base_rel, t, last_kind;
      base_done = done_cnt;
      base_rel  = rel_cnt;
      t = 0;
      @(negedge clk);
      while (!tx_if.tx_ready && t < TMO) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", 32'(t < TMO), 32'd1);
      tx_if.tx_data  = b;
      tx_if.tx_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
      chk("accept_busy", 32'(tx_if.busy), 32'd1);
      tx_if.tx_valid = 1'b0;
      dev_attempt(k1, s1, base_rel + 1, b);
      last_kind = k1;
      if (RETRY && (k1 == 1 || k1 == 2)) begin
         dev_attempt(k2, s2, base_rel + 2, b);
         last_kind = k2;
      end
      t = 0;
      while (done_cnt == base_done && t < TMO) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk({nm, "_done_count"}, 32'(done_cnt - base_done), 32'd1);
      chk({nm, "_err_code"}, 32'(done_err), 32'(exp_err));
      chk({nm, "_ack_ok"}, 32'(done_ack), 32'(exp_ack));
      chk({nm, "_clk_released"}, 32'(ps2_clk_oe), 32'd0);
      chk({nm, "_data_released"}, 32'(ps2_data_oe), 32'd0);
      chk({nm, "_ready_after_done"}, 32'(ready_after), 32'd1);
      if (last_kind == 3)
         chk({nm, "_start_tmo_cycles"}, 32'(done_cyc - rel_cyc), 32'(START_T));
      if (last_kind == 2)
         chk({nm, "_xfer_tmo_window"},
             32'((done_cyc - fall_cyc >= XFER_T) && (done_cyc - fall_cyc <= XFER_T + 5)), 32'd1);
   endtask

   vec_t vecs[6];

   initial begin
      int t, base_done, base_rel, r, k1, k2, s1, s2;
      logic [7:0] b;
      logic [2:0] m;

      vecs[0] = '{"ed_ack",     8'hED, 0, 0, 0, 0, 2'b00, 1'b1};
      vecs[1] = '{"zero_ack",   8'h00, 0, 0, 0, 0, 2'b00, 1'b1};
      vecs[2] = '{"no_clock",   8'hFF, 3, 0, 0, 0, 2'b01, 1'b0};
`ifdef PS2_TX_RETRY_EN
      vecs[3] = '{"nack_retry", 8'hA5, 1, 0, 0, 0, 2'b00, 1'b1};
`else
      vecs[3] = '{"nack_retry", 8'hA5, 1, 0, 0, 0, 2'b11, 1'b0};
`endif
      vecs[4] = '{"stall5",     8'h3C, 2, 5, 2, 5, 2'b10, 1'b0};
      vecs[5] = '{"nack_nack",  8'h01, 1, 0, 1, 0, 2'b11, 1'b0};

      tx_if.tx_data  = 8'h00;
      tx_if.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_ready", 32'(tx_if.tx_ready), 32'd1);
      chk("rst_busy", 32'(tx_if.busy), 32'd0);
      chk("rst_done", 32'(tx_if.done), 32'd0);
      chk("rst_ack_ok", 32'(tx_if.ack_ok), 32'd0);
      chk("rst_err_code", 32'(tx_if.err_code), 32'd0);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++)
         do_txn(vecs[i].name, vecs[i].data, vecs[i].k1, vecs[i].s1, vecs[i].k2, vecs[i].s2,
                vecs[i].err, vecs[i].ack);

      // Random bytes and device behaviours against the outcome model.
      for (int i = 0; i < 8; i++) begin
         b  = 8'($urandom_range(0, 255));
         r  = int'($urandom_range(0, 9));
         k1 = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
         k2 = int'($urandom_range(0, 2));
         s1 = int'($urandom_range(1, 10));
         s2 = int'($urandom_range(1, 10));
         m  = model_outcome(k1, k2);
         do_txn("rand", b, k1, s1, k2, s2, m[1:0], m[2]);
      end

      // Reset in the middle of SHIFT: lines drop at once, no done pulse.
      base_done = done_cnt;
      base_rel  = rel_cnt;
      @(negedge clk);
      tx_if.tx_data  = 8'hA5;
      tx_if.tx_valid = 1'b1;
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
      t = 0;
      while (rel_cnt == base_rel && t < TMO) begin
         @(negedge clk);
         t++;
      end
      chk("rstmid_release_seen", 32'(t < TMO), 32'd1);
      repeat (10) @(negedge clk);
      for (int e = 0; e < 5; e++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (e < 4) begin
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
         end
      end
      chk("rstmid_bit4_driven", 32'(ps2_data_oe), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_data_oe", 32'(ps2_data_oe), 32'd0);
      chk("rstmid_clk_oe", 32'(ps2_clk_oe), 32'd0);
      dev_clk = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_tx_ready", 32'(tx_if.tx_ready), 32'd1);
      chk("rstmid_busy", 32'(tx_if.busy), 32'd0);
      repeat (20) @(negedge clk);
      chk("rstmid_no_done", 32'(done_cnt - base_done), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
